// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: active-low hex font, blank code, font lookup
// and 4-bit Gray-to-binary conversion used by seg7_scan_driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry k is the active-low {g,f,e,d,c,b,a} pattern for hex digit k.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    return SEG_FONT[nib];
  endfunction

  function automatic logic [3:0] gray2bin(input logic [3:0] gray);
    logic [3:0] bin;
    bin[3] = gray[3];
    bin[2] = bin[3] ^ gray[2];
    bin[1] = bin[2] ^ gray[1];
    bin[0] = bin[1] ^ gray[0];
    return bin;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_button_debounce.sv
// Front-panel button conditioning: 2-FF synchroniser, stability counter,
// debounced level (released = 1) and a one-cycle pulse on each new press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_pi,
  input  logic rst_n_pi,
  input  logic button_pi,
  output logic press_po
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic          press_r;
  logic [CW-1:0] stable_cnt_r;

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= button_pi;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive samples disagreeing with the accepted level; a sample
  // that agrees again means the input bounced, so the count restarts.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      stable_cnt_r <= CW'(0);
      level_r      <= 1'b1;
    end else if (sync2_r == level_r) begin
      stable_cnt_r <= CW'(0);
    end else if (stable_cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_cnt_r <= CW'(0);
      level_r      <= sync2_r;
    end else begin
      stable_cnt_r <= stable_cnt_r + CW'(1);
    end
  end

  // Registered falling-edge detector on the debounced level.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      level_d_r <= 1'b1;
      press_r   <= 1'b0;
    end else begin
      level_d_r <= level_r;
      press_r   <= level_d_r & ~level_r;
    end
  end

  assign press_po = press_r;

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed common-anode 7-segment driver with press-to-freeze and
// per-digit blanking. Define SEG7_GRAY_DECODE_EN to decode nibbles as Gray code.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS        = 4,
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk_pi,
  input  logic                    rst_n_pi,
  input  logic [4*N_DIGITS-1:0]   value_pi,
  input  logic                    load_pi,
  input  logic [N_DIGITS-1:0]     digit_en_pi,
  input  logic                    button_pi,
  output logic [N_DIGITS-1:0]     anodo_po,
  output logic [6:0]              catodo_po,
  output logic                    frozen_po
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int NS = 2 ** IW;

  logic [4*N_DIGITS-1:0] value_r;
  logic                  frozen_r;
  logic [IW-1:0]         idx_r;
  logic [RW-1:0]         refresh_cnt_r;
  logic [N_DIGITS-1:0]   anodo_r;
  logic [6:0]            catodo_r;

  logic                  press_s;
  logic [3:0]            nib_s;
  logic [3:0]            code_s;
  logic [N_DIGITS-1:0]   anodo_s;
  logic [3:0]            nib_a [NS];
  logic [NS-1:0]         en_a;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .clk_pi   (clk_pi),
    .rst_n_pi (rst_n_pi),
    .button_pi(button_pi),
    .press_po (press_s)
  );

  // Index-addressable views padded to a power of two so any idx_r is in range.
  for (genvar k = 0; k < NS; k++) begin : g_slot
    if (k < N_DIGITS) begin : g_used
      assign nib_a[k] = value_r[4*k +: 4];
      assign en_a[k]  = digit_en_pi[k];
    end else begin : g_pad
      assign nib_a[k] = 4'h0;
      assign en_a[k]  = 1'b0;
    end
  end

  // Refresh counter and digit index.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      refresh_cnt_r <= RW'(0);
      idx_r         <= IW'(0);
    end else if (refresh_cnt_r == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt_r <= RW'(0);
      idx_r         <= (idx_r == IW'(N_DIGITS - 1)) ? IW'(0) : idx_r + IW'(1);
    end else begin
      refresh_cnt_r <= refresh_cnt_r + RW'(1);
    end
  end

  // Capture and freeze; the load sees frozen_r before this edge's toggle.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      value_r  <= {(4*N_DIGITS){1'b0}};
      frozen_r <= 1'b0;
    end else begin
      if (load_pi && !frozen_r) begin
        value_r <= value_pi;
      end
      if (press_s) begin
        frozen_r <= ~frozen_r;
      end
    end
  end

  // Select the active nibble, optionally Gray-decode it, and form the anode pattern.
  always_comb begin
    nib_s = nib_a[idx_r];
`ifdef SEG7_GRAY_DECODE_EN
    code_s = gray2bin(nib_s);
`else
    code_s = nib_s;
`endif
    anodo_s = {N_DIGITS{1'b1}};
    for (int k = 0; k < N_DIGITS; k++) begin
      anodo_s[k] = (idx_r != IW'(k));
    end
  end

  // Output register: lit digit or blank.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      anodo_r  <= {N_DIGITS{1'b1}};
      catodo_r <= SEG_BLANK;
    end else if (en_a[idx_r]) begin
      anodo_r  <= anodo_s;
      catodo_r <= seg_lookup(code_s);
    end else begin
      anodo_r  <= {N_DIGITS{1'b1}};
      catodo_r <= SEG_BLANK;
    end
  end

  assign anodo_po  = anodo_r;
  assign catodo_po = catodo_r;
  assign frozen_po = frozen_r;

endmodule
